// File: rtl/arbitro_mux.sv
// Round-robin arbiter driving the select of the shared 4:1 datapath mux; all outputs registered.
// Define ARB_QUANTUM_EN to preempt an owner after QUANTUM consecutive cycles when others are waiting.
module arbitro_mux #(
    parameter int QUANTUM = 8,
    parameter int CW      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] selecm,
    output logic       valid
);

    // state   | meaning
    // IDLE    | nobody owns the bus, waiting for any request
    // OCUPADO | gnt/selecm point at the current owner
    typedef enum logic {IDLE, OCUPADO} state_t;

    state_t         state;
    logic [1:0]     ptr;
    logic [CW-1:0]  counter;

    logic [3:0]     cand;
    logic           found;
    logic [1:0]     winner;
    logic [1:0]     idx;
    logic           owner_req;
    logic           preempt;

    // The owner is masked out of the scan: on release its req is already low,
    // and on preemption it must not re-win; in IDLE gnt is zero so nothing is masked.
    always_comb begin
        cand   = req & ~gnt;
        found  = 1'b0;
        winner = ptr;
        idx    = '0;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (cand[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign owner_req = |(req & gnt);

`ifdef ARB_QUANTUM_EN
    assign preempt = (counter == CW'(QUANTUM)) && found;
`else
    assign preempt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            gnt     <= '0;
            selecm  <= '0;
            valid   <= 1'b0;
            counter <= '0;
            ptr     <= '0;
        end else if (state == IDLE || !owner_req || preempt) begin
            if (found) begin
                state   <= OCUPADO;
                gnt     <= 4'b0001 << winner;
                selecm  <= winner;
                valid   <= 1'b1;
                counter <= CW'(1);
                ptr     <= winner + 2'd1;
            end else begin
                // selecm keeps the last owner's index
                state   <= IDLE;
                gnt     <= '0;
                valid   <= 1'b0;
                counter <= '0;
            end
        end else if (counter != {CW{1'b1}}) begin
            counter <= counter + CW'(1);
        end
    end

endmodule

// File: tb/tb_arbitro_mux.sv
// Directed self-checking bench for arbitro_mux: expected grants are hand-computed per step.
module tb_arbitro_mux;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] selecm;
    logic       valid;

    int checks = 0;
    int errors = 0;

    arbitro_mux #(.QUANTUM(8), .CW(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .gnt    (gnt),
        .selecm (selecm),
        .valid  (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] es, input logic ev);
        checks++;
        assert ({gnt, selecm, valid} === {eg, es, ev})
        else begin
            errors++;
            $error("FAIL %s: got gnt=%b selecm=%b valid=%b expected gnt=%b selecm=%b valid=%b",
                   tag, gnt, selecm, valid, eg, es, ev);
        end
    endtask

    // Advance one edge, then check the structural invariants on the new outputs.
    task automatic tick();
        logic sel_ok;
        @(posedge clk);
        #1;
        checks++;
        assert (((gnt & (gnt - 4'd1)) === 4'd0) && (valid === |gnt))
        else begin
            errors++;
            $error("FAIL invariant: got gnt=%b valid=%b expected onehot0 gnt and valid=|gnt", gnt, valid);
        end
        sel_ok = !valid || (gnt === (4'b0001 << selecm));
        checks++;
        assert (sel_ok === 1'b1)
        else begin
            errors++;
            $error("FAIL sel_match: got selecm=%b gnt=%b expected selecm indexing gnt", selecm, gnt);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        do_reset();
        chk("reset", 4'b0000, 2'b00, 1'b0);

        // req=0101: R_0 first, then back-to-back R_2 on release
        req = 4'b0101;
        tick();
        chk("first_grant", 4'b0001, 2'b00, 1'b1);
        tick();
        chk("hold_r0", 4'b0001, 2'b00, 1'b1);
        req = 4'b0100;
        tick();
        chk("b2b_r2", 4'b0100, 2'b10, 1'b1);
        req = 4'b0000;
        tick();
        chk("idle_after_r2", 4'b0000, 2'b10, 1'b0);

        // all requesting, each holds 3 granted cycles then drops and re-raises
        do_reset();
        req = 4'b1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            int k;
            k = i % 4;
            for (int c = 0; c < 3; c++) begin
                chk($sformatf("rr_%0d_c%0d", i, c), 4'(1 << k), 2'(k), 1'b1);
                if (c < 2) tick();
            end
            req[k] = 1'b0;
            tick();
            req[k] = 1'b1;
        end
        chk("rr_after_r0", 4'b0010, 2'b01, 1'b1);
        req = 4'b0000;
        tick();
        tick();
        chk("rr_idle", 4'b0000, 2'b01, 1'b0);

        // single requester R_1 for 4 cycles, selecm holds after release
        do_reset();
        req = 4'b0010;
        tick();
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("r1_hold_%0d", c), 4'b0010, 2'b01, 1'b1);
            if (c < 3) tick();
        end
        req = 4'b0000;
        tick();
        chk("r1_release", 4'b0000, 2'b01, 1'b0);
        tick();
        chk("r1_sel_held", 4'b0000, 2'b01, 1'b0);

        // reset in the middle of an R_2 grant, then pointer back at 0
        req = 4'b0100;
        tick();
        chk("r2_grant", 4'b0100, 2'b10, 1'b1);
        reset = 1'b1;
        req   = 4'b1100;
        tick();
        chk("reset_drop", 4'b0000, 2'b00, 1'b0);
        reset = 1'b0;
        tick();
        chk("post_reset_r2", 4'b0100, 2'b10, 1'b1);

        // R_1 held, R_3 joins in cycle 3
        do_reset();
        req = 4'b0010;
        tick();
        for (int g = 1; g <= 8; g++) begin
            if (g == 3) req = 4'b1010;
            chk($sformatf("q_r1_%0d", g), 4'b0010, 2'b01, 1'b1);
            tick();
        end
`ifdef ARB_QUANTUM_EN
        chk("q_preempt", 4'b1000, 2'b11, 1'b1);
`else
        for (int g = 9; g <= 14; g++) begin
            chk($sformatf("q_keep_%0d", g), 4'b0010, 2'b01, 1'b1);
            tick();
        end
`endif

        // lone requester never preempted
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk($sformatf("solo_%0d", c), 4'b0001, 2'b00, 1'b1);
        end
        req = 4'b0000;
        tick();
        chk("solo_release", 4'b0000, 2'b00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
